// File: rtl/fpu_cmp_scheduler.sv
// rtl/fpu_cmp_scheduler.sv - round-robin scheduler sharing one magnitude-difference unit
//
// fpu_comparator: combinational |a-b|, a<b sign and overflow flag.
//   a, b  : unsigned operands
//   diff  : |a-b|
//   sign  : 1 when a<b
//   ovf   : operand MSBs differ and a's MSB differs from sign
//
// fpu_cmp_scheduler: two requesters share one fpu_comparator.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   reqN_valid/reqN_a/reqN_b        : requester N operands
//   reqN_ready                      : requester N accepted this cycle (IDLE only)
//   res_valid/res_ready             : result handshake
//   res_id/res_diff/res_sign/res_ovf: registered result and owning requester
//   busy                            : an operation is in flight or held

module fpu_comparator #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             sign,
    output logic             ovf
);
    always_comb begin
        sign = (a < b);
        diff = sign ? (b - a) : (a - b);
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (a[WIDTH-1] != sign);
    end
endmodule

module fpu_cmp_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_sign,
    output logic             res_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rr_ptr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_id;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] cmp_diff;
    logic             cmp_sign;
    logic             cmp_ovf;

    fpu_comparator #(.WIDTH(WIDTH)) u_cmp (
        .a    (op_a),
        .b    (op_b),
        .diff (cmp_diff),
        .sign (cmp_sign),
        .ovf  (cmp_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rr_ptr==0 favours requester 0 when both are valid.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || !rr_ptr);
                grant1 = req1_valid && !grant0;
                if (grant0 || grant1) begin
                    state_next = CALC;
                end
            end
            CALC: state_next = RESP;
            RESP: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted even though state reads IDLE.
    assign req0_ready = grant0 && rst_n;
    assign req1_ready = grant1 && rst_n;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_diff  <= '0;
            res_sign  <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a  <= grant1 ? req1_a : req0_a;
                        op_b  <= grant1 ? req1_b : req0_b;
                        op_id <= grant1;
                    end
                end
                CALC: begin
                    res_diff  <= cmp_diff;
                    res_sign  <= cmp_sign;
                    res_ovf   <= cmp_ovf;
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        // The requester just served loses priority next time.
                        rr_ptr    <= ~res_id;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_cmp_scheduler.sv
// tb/tb_fpu_cmp_scheduler.sv - self-checking bench for fpu_cmp_scheduler

module tb_fpu_cmp_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        res_valid, res_ready, res_id, res_sign, res_ovf, busy;
    logic [31:0] res_diff;

    always #5 clk = ~clk;

    fpu_cmp_scheduler #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_diff   (res_diff),
        .res_sign   (res_sign),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    typedef struct {
        logic        id;
        logic [31:0] diff;
        logic        sign;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        sign;
        logic        ovf;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    logic acc0, acc1;
    exp_t exp0, exp1;
    exp_t sb[$];
    logic id_log[$];
    vec_t vecs[8];

    function automatic exp_t model(logic id, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.id   = id;
        e.sign = (a < b) ? 1'b1 : 1'b0;
        e.diff = e.sign ? (b - a) : (a - b);
        e.ovf  = (a[31] != b[31]) && (a[31] != e.sign);
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    // One clock: observe handshakes at the falling edge, return 1ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                e = sb.pop_front();
                check("res_id", res_id, e.id);
                check("res_diff", res_diff, e.diff);
                check("res_sign", res_sign, e.sign);
                check("res_ovf", res_ovf, e.ovf);
            end
            id_log.push_back(res_id);
            n_done++;
        end
        if (acc0) sb.push_back(exp0);
        if (acc1) sb.push_back(exp1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic port, logic [31:0] a, logic [31:0] b, exp_t e);
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; exp1 = e;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; exp0 = e;
        end
    endtask

    task automatic send(logic port, logic [31:0] a, logic [31:0] b, exp_t e);
        bit got = 0;
        drive(port, a, b, e);
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            got = port ? acc1 : acc0;
        end
        if (!got) fail_now("accept");
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_done(int target, int budget);
        for (int c = 0; c < budget && n_done < target; c++) tick();
        if (n_done < target) fail_now("result_wait");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #12;
        sb.delete();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   base;
        logic [31:0] ra[4], rb[4];
        int   i0, i1;
        bit   seen;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0003, 32'h0000_0010, 32'h0000_000D, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h9000_0000, 32'h8000_0001, 32'h0FFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

        // Reset state, with both requesters asserting valid during reset.
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h5; req0_b = 32'h3; req1_a = 32'h7; req1_b = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_res_diff", res_diff, 0);
        check("rst_res_id", res_id, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single request: latency and one-cycle ready pulse.
        res_ready = 1'b1;
        drive(0, 32'h10, 32'h3, '{1'b0, 32'hD, 1'b0, 1'b0});
        tick();
        check("single_accept", acc0, 1);
        check("single_ready_drops", req0_ready, 0);
        check("single_busy", busy, 1);
        check("single_no_early_result", res_valid, 0);
        req0_valid = 1'b0;
        tick();
        check("single_res_valid", res_valid, 1);
        check("single_res_id", res_id, 0);
        check("single_res_diff", res_diff, 32'hD);
        tick();
        check("single_consumed", res_valid, 0);
        check("single_idle", busy, 0);
        check("single_done", n_done, 1);

        // Table vectors through the scoreboard.
        for (int k = 0; k < 8; k++) begin
            base = n_done;
            e = '{vecs[k].id, vecs[k].diff, vecs[k].sign, vecs[k].ovf};
            send(vecs[k].id, vecs[k].a, vecs[k].b, e);
            wait_done(base + 1, 10);
        end

        // Round-robin with both requesters continuously valid.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
        i0 = 0; i1 = 0;
        id_log.delete();
        base = n_done;
        drive(0, ra[0], rb[0], model(0, ra[0], rb[0]));
        drive(1, ra[2], rb[2], model(1, ra[2], rb[2]));
        for (int c = 0; c < 40 && n_done < base + 4; c++) begin
            tick();
            if (acc0) begin
                i0++;
                if (i0 < 2) drive(0, ra[i0], rb[i0], model(0, ra[i0], rb[i0]));
                else req0_valid = 1'b0;
            end
            if (acc1) begin
                i1++;
                if (i1 < 2) drive(1, ra[2+i1], rb[2+i1], model(1, ra[2+i1], rb[2+i1]));
                else req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count", id_log.size(), 4);
        for (int k = 0; k < 4 && k < id_log.size(); k++)
            check($sformatf("rr_id_%0d", k), id_log[k], k % 2);

        // Back-pressure: result held while req1 waits, req1 granted after release.
        res_ready = 1'b0;
        send(0, 32'h1234, 32'h0234, '{1'b0, 32'h1000, 1'b0, 1'b0});
        drive(1, 32'h55, 32'h66, '{1'b1, 32'h11, 1'b1, 1'b0});
        seen = 0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            seen = res_valid;
        end
        if (!seen) fail_now("bp_res_valid");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid_held", res_valid, 1);
            check("bp_diff_held", res_diff, 32'h1000);
            check("bp_id_held", res_id, 0);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
        end
        res_ready = 1'b1;
        #1;
        check("bp_no_bypass", req1_ready, 0);
        base = n_done;
        tick();
        check("bp_consumed", n_done, base + 1);
        tick();
        check("bp_req1_granted", acc1, 1);
        req1_valid = 1'b0;
        wait_done(base + 2, 10);

        // Reset in the middle of CALC discards the operation.
        send(0, 32'h5, 32'h3, '{1'b0, 32'h2, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_busy", busy, 0);
        sb.delete();
        #3;
        rst_n = 1'b1;
        base = n_done;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("postrst_no_result", res_valid, 0);
        end
        check("postrst_no_done", n_done, base);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
